stage_if_pf: RTL and testbench
==============================

STAGE_IF_PF -- requirements
Module: stage_if_pf

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, prefetch entries (power of two, 2..16).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, granted-but-unanswered memory requests (1..FIFO_DEPTH).
REQ-004 SHALL have ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- branch_addr_i  in  32  redirect target.
- sel_addr_i  in  1  redirect strobe.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  in-order response valid; cannot be stalled.
- imem_rdata_i  in  32  response word.
- valid_o  out  1  instruction available to decode.
- stall_i  in  1  decode cannot accept; entry held.
- instr_o  out  32  instruction word.
- pc_o  out  32  address of instr_o.
- mis_addr_exc_o  out  1  entry is a misaligned-fetch exception.

Function
REQ-005 SHALL issue a request when state is FETCH and FIFO occupancy + in-flight < FIFO_DEPTH and in-flight < MAX_OUTSTANDING; after a grant, fetch PC advances by 4 (wraps modulo 2^32).
REQ-006 SHALL hold imem_req_o/imem_addr_o stable until imem_gnt_i, except on redirect, which may retract or replace them.
REQ-007 SHALL push each non-discarded response as {pc, rdata, exc=0}; pc values are consecutive in grant order.
REQ-008 SHALL present the FIFO head on valid_o/instr_o/pc_o/mis_addr_exc_o; the head pops when valid_o=1 and stall_i=0.
REQ-009 SHALL, on sel_addr_i=1: flush the FIFO the same cycle. Fetch PC becomes branch_addr_i. Every in-flight request, including one granted in that cycle, is added to a discard counter. The next imem_req_o is no earlier than the following cycle.
REQ-010 SHALL drop responses while the discard counter is nonzero, decrementing it by one per response; none are pushed.
REQ-011 SHALL, if the redirect target has [1:0]≠0, issue no request. It enters state EXC, pushes one entry {pc=target, instr=0, exc=1} once stale responses are drained, and stays in EXC until the next redirect.
REQ-012 SHALL have FSM states FETCH and EXC; transitions occur only on redirect (alignment of target selects the state).
REQ-013 SHALL give redirect priority over a same-cycle pop, push and grant; a same-cycle push and pop with a non-full FIFO keeps occupancy unchanged.
REQ-014 SHALL have latency: first valid_o no earlier than 1 cycle after the response is pushed (without STAGE_IF_BYPASS_EN).

Reset
REQ-015 SHALL, while rst_i=1, hold fetch PC=RESET_VECTOR, FIFO empty, discard and in-flight counters 0, state FETCH, imem_req_o=0, valid_o=0, mis_addr_exc_o=0. instr_o and pc_o are 0.
REQ-016 SHALL ignore responses arriving while rst_i=1; reset mid-operation abandons in-flight requests, and the memory side is reset together.
REQ-017 SHALL assert imem_req_o for RESET_VECTOR in the first cycle after rst_i deasserts.

Configuration
REQ-018 SHALL, with STAGE_IF_BYPASS_EN defined, forward a non-discarded response directly to the outputs in the same cycle when the FIFO is empty and not stalled, without storing it. If stall_i=1, the response is pushed normally.
REQ-019 SHALL, without STAGE_IF_BYPASS_EN, always register responses through the FIFO (REQ-014).

Structure
REQ-020 SHALL place the following in package stage_if_pkg:
- default parameter constants;
- the FSM state encoding;
- the FIFO entry typedef {pc[31:0], instr[31:0], exc}.
REQ-021 SHALL implement storage in sub-module if_fifo (parametrised depth, flush, push, pop, full/empty, count).

Verification
REQ-022 Reset, RESET_VECTOR=32'h100, zero-wait memory -> requests 0x100, 0x104, 0x108; outputs pc_o 0x100/0x104/0x108 in order.
REQ-023 stall_i=1 for 10 cycles -> no more than FIFO_DEPTH+MAX_OUTSTANDING words fetched; nothing lost or duplicated after release.
REQ-024 Redirect to 0x200 with 2 requests in flight -> both stale responses dropped; next valid_o has pc_o=0x200.
REQ-025 Redirect to 0x202 -> no imem_req_o; a single entry with pc_o=0x202, mis_addr_exc_o=1. Redirect to 0x300 resumes fetching.
REQ-026 Fetch PC 0xFFFF_FFFC -> next request 0x0000_0000.
REQ-027 Response arriving with FIFO empty and stall_i=0 -> valid_o in the same cycle (STAGE_IF_BYPASS_EN) or the next cycle (without it).

Source files
------------

// File: rtl/stage_if_pkg.sv
// Shared types and defaults for the instruction-fetch prefetch stage.
package stage_if_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF    = 32'h0000_0000;
    localparam int          FIFO_DEPTH_DEF      = 4;
    localparam int          MAX_OUTSTANDING_DEF = 2;
    localparam int          CNT_W               = 5;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXC   = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } entry_t;

endpackage

// File: rtl/if_fifo.sv
// Prefetch storage: circular buffer of fetch entries with same-cycle flush.
module if_fifo
    import stage_if_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  entry_t      wdata,
    input  logic        pop,
    output entry_t      rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    entry_t      mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    assign count   = wptr - rptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/stage_if_pf.sv
// Fetch/prefetch stage with redirect, stale-response discard and misaligned-target exception.
// Optional STAGE_IF_BYPASS_EN forwards a response to decode in the cycle it arrives.
module stage_if_pf
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR    = RESET_VECTOR_DEF,
    parameter int          FIFO_DEPTH      = FIFO_DEPTH_DEF,
    parameter int          MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    localparam int         AW              = $clog2(FIFO_DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] branch_addr_i,
    input  logic        sel_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    input  logic        stall_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        mis_addr_exc_o
);

    state_e           state_q;
    state_e           state_d;
    logic             fetch_en;
    logic [31:0]      pc_q;
    logic [31:0]      resp_pc_q;
    logic [CNT_W-1:0] live_q;
    logic [CNT_W-1:0] stale_q;
    logic [CNT_W-1:0] occ;
    logic             exc_pend_q;

    entry_t           head;
    entry_t           push_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_cnt;

    logic             gnt_fire;
    logic             resp_live;
    logic             resp_drop;
    logic             exc_push;
    logic             bypass;
    logic             push;
    logic             pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (sel_addr_i) begin
            state_d = (branch_addr_i[1:0] != 2'b00) ? ST_EXC : ST_FETCH;
        end
    end

    always_comb begin
        fetch_en = (state_q == ST_FETCH);
    end

    // Stale requests still occupy the memory's outstanding slots.
    assign occ        = CNT_W'(fifo_cnt) + live_q;
    assign imem_req_o = !rst_i && fetch_en
                     && (occ < CNT_W'(FIFO_DEPTH))
                     && ((live_q + stale_q) < CNT_W'(MAX_OUTSTANDING));
    assign imem_addr_o = pc_q;

    assign gnt_fire  = imem_req_o && imem_gnt_i;
    assign resp_drop = imem_rvalid_i && (stale_q != '0);
    assign resp_live = imem_rvalid_i && (stale_q == '0) && !sel_addr_i;
    assign exc_push  = exc_pend_q && (stale_q == '0) && !sel_addr_i;

`ifdef STAGE_IF_BYPASS_EN
    assign bypass = !rst_i && resp_live && fifo_empty && !stall_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = !rst_i && !fifo_full
               && ((resp_live && !bypass) || exc_push);
    assign pop  = valid_o && !stall_i && !fifo_empty && !sel_addr_i;

    always_comb begin
        push_data.pc    = resp_pc_q;
        push_data.instr = exc_push ? 32'h0 : imem_rdata_i;
        push_data.exc   = exc_push;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_VECTOR;
            resp_pc_q  <= RESET_VECTOR;
            live_q     <= '0;
            stale_q    <= '0;
            exc_pend_q <= 1'b0;
        end else if (sel_addr_i) begin
            pc_q       <= branch_addr_i;
            resp_pc_q  <= branch_addr_i;
            live_q     <= '0;
            stale_q    <= stale_q + live_q + CNT_W'(gnt_fire)
                        - CNT_W'(imem_rvalid_i);
            exc_pend_q <= (branch_addr_i[1:0] != 2'b00);
        end else begin
            if (gnt_fire)  pc_q      <= pc_q + 32'd4;
            if (resp_live) resp_pc_q <= resp_pc_q + 32'd4;
            live_q  <= live_q + CNT_W'(gnt_fire) - CNT_W'(resp_live);
            stale_q <= stale_q - CNT_W'(resp_drop);
            if (exc_push) exc_pend_q <= 1'b0;
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (sel_addr_i),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        valid_o        = 1'b0;
        instr_o        = 32'h0;
        pc_o           = 32'h0;
        mis_addr_exc_o = 1'b0;
        if (!rst_i && !fifo_empty) begin
            valid_o        = 1'b1;
            instr_o        = head.instr;
            pc_o           = head.pc;
            mis_addr_exc_o = head.exc;
        end else if (bypass) begin
            valid_o = 1'b1;
            instr_o = imem_rdata_i;
            pc_o    = resp_pc_q;
        end
    end

endmodule

// File: tb/tb_stage_if_pf.sv
// Self-checking bench for stage_if_pf: memory model, scoreboard and redirect table.
module tb_stage_if_pf;
    import stage_if_pkg::*;

    localparam logic [31:0] RV    = 32'h100;
    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0F0F;
`ifdef STAGE_IF_BYPASS_EN
    localparam logic        BYP   = 1'b1;
`else
    localparam logic        BYP   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] branch_addr_i;
    logic        sel_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic        stall_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        mis_addr_exc_o;

    always #5 clk = ~clk;

    stage_if_pf #(
        .RESET_VECTOR    (RV),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .branch_addr_i  (branch_addr_i),
        .sel_addr_i     (sel_addr_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .valid_o        (valid_o),
        .stall_i        (stall_i),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .mis_addr_exc_o (mis_addr_exc_o)
    );

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic        exp_exc;
        logic        exp_req;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem_q[$];
    entry_t      exp_q[$];
    logic [31:0] gaddr[$];
    logic [31:0] pop_pcs[$];
    logic [31:0] model_pc;
    logic        gnt_en, resp_en, resp_rand;
    int          grants, pops, req_seen;
    logic        first_seen, first_exc, last_valid;
    logic [31:0] first_pc;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic check(input string name, input logic [64:0] act,
                         input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic sl, input logic [31:0] tgt);
        entry_t e;
        @(negedge clk);
        stall_i       = st;
        sel_addr_i    = sl;
        branch_addr_i = tgt;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        if (resp_en && mem_q.size() > 0 &&
            (!resp_rand || $urandom_range(1, 0) == 1)) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = word(mem_q.pop_front());
        end
        imem_gnt_i = gnt_en && imem_req_o;
        if (imem_req_o) req_seen++;
        if (imem_gnt_i) begin
            check("grant_addr", {33'h0, imem_addr_o}, {33'h0, model_pc});
            grants++;
            gaddr.push_back(imem_addr_o);
            mem_q.push_back(imem_addr_o);
            if (!sl) exp_q.push_back('{pc: model_pc, instr: word(model_pc), exc: 1'b0});
            model_pc = model_pc + 32'd4;
        end
        if (sl) begin
            exp_q.delete();
            model_pc = tgt;
            if (tgt[1:0] != 2'b00) exp_q.push_back('{pc: tgt, instr: 32'h0, exc: 1'b1});
        end
        #1;
        last_valid = valid_o;
        if (valid_o && !st && !sl) begin
            pops++;
            pop_pcs.push_back(pc_o);
            if (!first_seen) begin
                first_seen = 1'b1;
                first_pc   = pc_o;
                first_exc  = mis_addr_exc_o;
            end
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got pc %0h, required no entry", pc_o);
            end else begin
                e = exp_q.pop_front();
                check("output_entry", {pc_o, instr_o, mis_addr_exc_o}, e);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i         = 1'b1;
        sel_addr_i    = 1'b0;
        stall_i       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_req", {64'h0, imem_req_o}, 65'h0);
            check("rst_valid_exc", {63'h0, valid_o, mis_addr_exc_o}, 65'h0);
            check("rst_pc_instr", {1'b0, pc_o, instr_o}, 65'h0);
        end
        @(negedge clk);
        rst_i         = 1'b0;
        imem_rvalid_i = 1'b0;
        mem_q.delete();
        exp_q.delete();
        model_pc = RV;
        #1;
        check("post_rst_req", {32'h0, imem_req_o, imem_addr_o}, {32'h0, 1'b1, RV});
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0000_0300, 32'h0000_0300, 1'b0, 1'b1};
        vecs[1] = '{32'h0000_0202, 32'h0000_0202, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0300, 32'h0000_0300, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_1001, 32'h0000_1001, 1'b1, 1'b0};
        vecs[4] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_0040, 32'h0000_0040, 1'b0, 1'b1};

        rst_i = 1'b1; sel_addr_i = 1'b0; branch_addr_i = 32'h0;
        stall_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0;
        gnt_en = 1'b0; resp_en = 1'b1; resp_rand = 1'b0;
        grants = 0; pops = 0; req_seen = 0;
        first_seen = 1'b0; first_pc = 32'h0; first_exc = 1'b0; last_valid = 1'b0;
        model_pc = RV;

        do_reset();

        // Zero-wait memory after reset
        gnt_en = 1'b1;
        gaddr.delete();
        pop_pcs.delete();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("reset_req_seq", {33'h0, (i < gaddr.size()) ? gaddr[i] : 32'hFFFF_FFFF},
                  {33'h0, RV + 32'(4 * i)});
            check("reset_out_seq", {33'h0, (i < pop_pcs.size()) ? pop_pcs[i] : 32'hFFFF_FFFF},
                  {33'h0, RV + 32'(4 * i)});
        end

        // Long stall bounds the fetch-ahead
        grants = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
        check("stall_fetch_bound", {64'h0, grants <= DEPTH + MAXO}, 65'h1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 32'h0);
        gnt_en = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
        check("drain_empty", 65'(exp_q.size()), 65'h0);

        // Redirect with two requests in flight
        gnt_en  = 1'b1;
        resp_en = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
        check("two_inflight", {63'h0, mem_q.size() == 2, imem_req_o}, 65'h2);
        first_seen = 1'b0;
        first_pc   = 32'hFFFF_FFFF;
        step(1'b0, 1'b1, 32'h0000_0200);
        resp_en = 1'b1;
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 32'h0);
        check("redirect_first_pc", {33'h0, first_pc}, {33'h0, 32'h0000_0200});
        check("redirect_first_exc", {64'h0, first_exc}, 65'h0);

        // Response latency into an empty FIFO
        gnt_en = 1'b0;
        step(1'b0, 1'b1, 32'h0000_0500);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
        gnt_en = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        gnt_en = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        check("lat_resp_cycle", {64'h0, last_valid}, {64'h0, BYP});
        step(1'b0, 1'b0, 32'h0);
        check("lat_next_cycle", {64'h0, last_valid}, {64'h0, !BYP});

        // Redirect table with random stalls and response timing
        gnt_en    = 1'b1;
        resp_rand = 1'b1;
        for (int v = 0; v < 6; v++) begin
            step(1'b0, 1'b1, vecs[v].target);
            first_seen = 1'b0;
            first_pc   = ~vecs[v].exp_pc;
            first_exc  = ~vecs[v].exp_exc;
            req_seen   = 0;
            pops       = 0;
            gaddr.delete();
            for (int i = 0; i < 25; i++)
                step($urandom_range(3, 0) == 0, 1'b0, 32'h0);
            check("tbl_first_pc", {33'h0, first_pc}, {33'h0, vecs[v].exp_pc});
            check("tbl_first_exc", {64'h0, first_exc}, {64'h0, vecs[v].exp_exc});
            check("tbl_req_seen", {64'h0, req_seen != 0}, {64'h0, vecs[v].exp_req});
            if (vecs[v].exp_req)
                check("tbl_next_addr",
                      {33'h0, (gaddr.size() > 1) ? gaddr[1] : ~(vecs[v].exp_pc + 32'd4)},
                      {33'h0, vecs[v].exp_pc + 32'd4});
            else
                check("tbl_single_exc", 65'(pops), 65'h1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
